store_commit_buffer: RTL and testbench
======================================

Name: store_commit_buffer

Overview:
- FIFO store buffer directly downstream of the retire stage.
- Accepts up to two committed store requests per cycle (slot 1 older than slot 2) and drains them in program order to data memory, one per cycle, over a valid/ready handshake.
- Offers a combinational store-to-load forwarding lookup, so younger loads see committed-but-undrained stores.
- Exports a registered space indication that the retire stage uses to gate store commit.

Parameters:
- DEPTH, 8, number of entries; power of two, minimum 2.
- ADDR_W, 32, store address width.
- DATA_W, 32, store data width.

Ports:
- clk  input  1  clock; all state updates on the rising edge.
- rst_n  input  1  asynchronous, active-low reset.
- req1_valid  input  1  slot-1 committed store present.
- req1_addr  input  ADDR_W  slot-1 store address.
- req1_data  input  DATA_W  slot-1 store data.
- req2_valid  input  1  slot-2 committed store present (younger than slot 1).
- req2_addr  input  ADDR_W  slot-2 store address.
- req2_data  input  DATA_W  slot-2 store data.
- space2  output  1  at least two free entries; registered.
- mem_wr_valid  output  1  head entry presented to memory.
- mem_wr_addr  output  ADDR_W  head address.
- mem_wr_data  output  DATA_W  head data.
- mem_wr_ready  input  1  memory accepts the head this cycle.
- fwd_addr  input  ADDR_W  load lookup address.
- fwd_hit  output  1  a buffered store matches fwd_addr.
- fwd_data  output  DATA_W  data of the youngest matching store.
- count  output  $clog2(DEPTH)+1  occupied entries.
- overflow  output  1  sticky error: a request was dropped.

Behaviour:
- Reset (asynchronous, rst_n=0):
  - head/tail pointers = 0, count = 0, overflow = 0.
  - mem_wr_valid = 0, fwd_hit = 0, space2 = 1.
  - Entry storage is not reset.
  - Asserting rst_n mid-operation discards all pending stores immediately.
- Enqueue:
  - Each cycle, valid slots are written at tail in order slot1, then slot2.
  - If only req2_valid is set, it is written at tail alone.
  - tail advances by the number of accepted requests, modulo DEPTH (wrap-around).
- space2 rule:
  - space2 = (count <= DEPTH-2), taken from the registered count.
  - A same-cycle pop never raises it, so there is no combinational path from mem_wr_ready.
  - Upstream presents stores only while space2=1.
- Overflow:
  - Free space for acceptance = DEPTH - count + pop_this_cycle.
  - Requests beyond free space are dropped, youngest first, and overflow sets to 1.
  - overflow clears only on reset.
- Drain:
  - mem_wr_valid = (count != 0). mem_wr_addr/mem_wr_data come combinationally from the head entry.
  - Pop occurs when mem_wr_valid & mem_wr_ready; head advances modulo DEPTH.
  - While valid and not ready, the outputs hold stable.
  - Latency: a store enqueued into an empty buffer appears on mem_wr_* the next cycle.
  - Throughput: one store per cycle.
- Simultaneous push and pop: count_next = count + pushes - pop, in the range 0..DEPTH.
- Forwarding:
  - Combinational full-width compare of fwd_addr against all occupied entries.
  - fwd_data comes from the youngest match (closest to tail).
  - Stores being enqueued in the current cycle are not searched.
  - The head entry being popped this cycle is still searched.
  - On no match: fwd_hit = 0 and fwd_data = 0.
- Reserved: no address-alignment checking and no merging of stores.

Test Plan:
- Reset, then dual push (A=0x100/D=0x11, B=0x104/D=0x22) with mem_wr_ready=1 -> next cycle mem_wr 0x100/0x11, following cycle 0x104/0x22, then mem_wr_valid=0, count=0.
- Fill 8 entries with mem_wr_ready=0 -> space2 falls to 0 once count=7; count=8; mem_wr_addr holds the first store's address; then raise ready -> 8 stores drain in order across the pointer wrap.
- Push 0x200/0xAA, later 0x200/0xBB, with ready=0; fwd_addr=0x200 -> fwd_hit=1, fwd_data=0xBB; fwd_addr=0x204 -> fwd_hit=0, fwd_data=0.
- count=8, ready=1, dual push -> one store accepted, slot2 dropped, overflow=1 and stays 1; count remains 8.
- Only req2_valid set (0x300/0x33) -> enqueued alone, drains as 0x300/0x33.
- Assert rst_n=0 asynchronously with 5 entries pending -> count=0 and mem_wr_valid=0 immediately; after release, no stale stores drain.

Source files
------------

// File: rtl/store_commit_buffer.sv
// Post-retire store FIFO: takes up to two committed stores per cycle, drains one
// per cycle to data memory, and serves store-to-load forwarding from undrained entries.
module store_commit_buffer #(
  parameter int DEPTH  = 8,
  parameter int ADDR_W = 32,
  parameter int DATA_W = 32,
  localparam int PTR_W = $clog2(DEPTH),
  localparam int CNT_W = PTR_W + 1
) (
  input  logic              clk,
  input  logic              rst_n,
  input  logic              req1_valid,
  input  logic [ADDR_W-1:0] req1_addr,
  input  logic [DATA_W-1:0] req1_data,
  input  logic              req2_valid,
  input  logic [ADDR_W-1:0] req2_addr,
  input  logic [DATA_W-1:0] req2_data,
  output logic              space2,
  output logic              mem_wr_valid,
  output logic [ADDR_W-1:0] mem_wr_addr,
  output logic [DATA_W-1:0] mem_wr_data,
  input  logic              mem_wr_ready,
  input  logic [ADDR_W-1:0] fwd_addr,
  output logic              fwd_hit,
  output logic [DATA_W-1:0] fwd_data,
  output logic [CNT_W-1:0]  count,
  output logic              overflow
);

  logic [ADDR_W-1:0] r_addr [DEPTH];
  logic [DATA_W-1:0] r_data [DEPTH];
  logic [PTR_W-1:0]  r_head, r_tail;
  logic [CNT_W-1:0]  r_count;
  logic              r_overflow, r_space2;

  logic              w_pop, w_drop, w_wr1, w_wr2;
  logic [1:0]        w_nreq, w_nacc;
  logic [CNT_W-1:0]  w_free, w_count_nxt;
  logic [PTR_W-1:0]  w_idx2;
  logic              w_fwd_hit;
  logic [DATA_W-1:0] w_fwd_data;

  assign w_pop  = (r_count != '0) && mem_wr_ready;
  // A same-cycle pop frees one slot for an incoming store.
  assign w_free = CNT_W'(DEPTH) - r_count + CNT_W'(w_pop);
  assign w_nreq = {1'b0, req1_valid} + {1'b0, req2_valid};
  assign w_drop = CNT_W'(w_nreq) > w_free;
  // When dropping, free is 0 or 1, so the oldest request keeps the slot.
  assign w_nacc = w_drop ? w_free[1:0] : w_nreq;
  assign w_wr1  = req1_valid && (w_nacc != 2'd0);
  assign w_wr2  = req2_valid && (req1_valid ? (w_nacc == 2'd2) : (w_nacc == 2'd1));
  assign w_idx2 = req1_valid ? r_tail + PTR_W'(1) : r_tail;
  assign w_count_nxt = r_count + CNT_W'(w_nacc) - CNT_W'(w_pop);

  always_ff @(posedge clk) begin
    if (w_wr1) begin
      r_addr[r_tail] <= req1_addr;
      r_data[r_tail] <= req1_data;
    end
    if (w_wr2) begin
      r_addr[w_idx2] <= req2_addr;
      r_data[w_idx2] <= req2_data;
    end
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      r_head     <= '0;
      r_tail     <= '0;
      r_count    <= '0;
      r_overflow <= 1'b0;
      r_space2   <= 1'b1;
    end else begin
      r_head     <= r_head + PTR_W'(w_pop);
      r_tail     <= r_tail + PTR_W'(w_nacc);
      r_count    <= w_count_nxt;
      r_overflow <= r_overflow | w_drop;
      r_space2   <= (w_count_nxt <= CNT_W'(DEPTH - 2));
    end
  end

  // Walk oldest to youngest so the last match wins; the popping head is still occupied.
  always_comb begin
    w_fwd_hit  = 1'b0;
    w_fwd_data = '0;
    for (int i = 0; i < DEPTH; i++) begin
      if ((CNT_W'(i) < r_count) && (r_addr[r_head + PTR_W'(i)] == fwd_addr)) begin
        w_fwd_hit  = 1'b1;
        w_fwd_data = r_data[r_head + PTR_W'(i)];
      end
    end
  end

  assign space2       = r_space2;
  assign mem_wr_valid = (r_count != '0);
  assign mem_wr_addr  = r_addr[r_head];
  assign mem_wr_data  = r_data[r_head];
  assign fwd_hit      = w_fwd_hit;
  assign fwd_data     = w_fwd_data;
  assign count        = r_count;
  assign overflow     = r_overflow;

endmodule

// File: tb/tb_store_commit_buffer.sv
// Directed bench for store_commit_buffer: queue-based reference model checked every
// negedge, plus hand-computed literal expectations at key points.
module tb_store_commit_buffer;
  localparam int DEPTH = 8;
  localparam int AW = 32;
  localparam int DW = 32;
  localparam int CW = $clog2(DEPTH) + 1;

  logic          clk, rst_n;
  logic          req1_valid, req2_valid, mem_wr_ready;
  logic [AW-1:0] req1_addr, req2_addr, fwd_addr, mem_wr_addr;
  logic [DW-1:0] req1_data, req2_data, mem_wr_data, fwd_data;
  logic          space2, mem_wr_valid, fwd_hit, overflow;
  logic [CW-1:0] count;

  store_commit_buffer #(.DEPTH(DEPTH), .ADDR_W(AW), .DATA_W(DW)) dut (
    .clk(clk), .rst_n(rst_n),
    .req1_valid(req1_valid), .req1_addr(req1_addr), .req1_data(req1_data),
    .req2_valid(req2_valid), .req2_addr(req2_addr), .req2_data(req2_data),
    .space2(space2),
    .mem_wr_valid(mem_wr_valid), .mem_wr_addr(mem_wr_addr), .mem_wr_data(mem_wr_data),
    .mem_wr_ready(mem_wr_ready),
    .fwd_addr(fwd_addr), .fwd_hit(fwd_hit), .fwd_data(fwd_data),
    .count(count), .overflow(overflow)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  int n_tot = 0;
  int n_pass = 0;

  task automatic chk(input string nm, input logic [63:0] act, input logic [63:0] exp);
    n_tot++;
    if (act === exp) n_pass++;
    else $display("FAIL %s: got %0h expected %0h (t=%0t)", nm, act, exp, $time);
  endtask

  // Reference model: program-ordered queue of buffered stores.
  logic [AW-1:0] mq_a[$];
  logic [DW-1:0] mq_d[$];
  bit            m_ovf;

  initial begin
    int fr;
    m_ovf = 0;
    forever begin
      @(posedge clk or negedge rst_n);
      if (!rst_n) begin
        mq_a.delete(); mq_d.delete(); m_ovf = 0;
      end else begin
        if (mq_a.size() > 0 && mem_wr_ready) begin
          void'(mq_a.pop_front()); void'(mq_d.pop_front());
        end
        fr = DEPTH - mq_a.size();
        if (req1_valid) begin
          if (fr > 0) begin mq_a.push_back(req1_addr); mq_d.push_back(req1_data); fr--; end
          else m_ovf = 1;
        end
        if (req2_valid) begin
          if (fr > 0) begin mq_a.push_back(req2_addr); mq_d.push_back(req2_data); fr--; end
          else m_ovf = 1;
        end
      end
    end
  end

  bit cmp_en = 0;
  always @(negedge clk) begin
    logic          e_hit;
    logic [DW-1:0] e_dat;
    if (cmp_en) begin
      e_hit = 0; e_dat = '0;
      for (int i = mq_a.size() - 1; i >= 0; i--)
        if (!e_hit && mq_a[i] == fwd_addr) begin e_hit = 1; e_dat = mq_d[i]; end
      chk("m_count", 64'(count), 64'(mq_a.size()));
      chk("m_valid", 64'(mem_wr_valid), 64'(mq_a.size() != 0));
      chk("m_space2", 64'(space2), 64'(mq_a.size() <= DEPTH - 2));
      chk("m_overflow", 64'(overflow), 64'(m_ovf));
      chk("m_fwd_hit", 64'(fwd_hit), 64'(e_hit));
      chk("m_fwd_data", 64'(fwd_data), 64'(e_dat));
      if (mq_a.size() != 0) begin
        chk("m_wr_addr", 64'(mem_wr_addr), 64'(mq_a[0]));
        chk("m_wr_data", 64'(mem_wr_data), 64'(mq_d[0]));
      end
    end
  end

  task automatic set1(input logic [AW-1:0] a, input logic [DW-1:0] d);
    req1_valid = 1; req1_addr = a; req1_data = d;
  endtask
  task automatic set2(input logic [AW-1:0] a, input logic [DW-1:0] d);
    req2_valid = 1; req2_addr = a; req2_data = d;
  endtask
  // Advance one cycle; returns at negedge+1 with requests cleared.
  task automatic cyc();
    @(posedge clk); #1;
    req1_valid = 0; req2_valid = 0;
    @(negedge clk); #1;
  endtask

  initial begin
    rst_n = 0; mem_wr_ready = 0; fwd_addr = 32'h104;
    req1_valid = 0; req1_addr = '0; req1_data = '0;
    req2_valid = 0; req2_addr = '0; req2_data = '0;
    repeat (2) @(posedge clk);
    cmp_en = 1;
    @(negedge clk); #1;
    chk("rst_count", 64'(count), 64'd0);
    chk("rst_valid", 64'(mem_wr_valid), 64'd0);
    chk("rst_space2", 64'(space2), 64'd1);
    chk("rst_overflow", 64'(overflow), 64'd0);
    chk("rst_fwd_hit", 64'(fwd_hit), 64'd0);
    rst_n = 1;

    // Dual push, immediate drain
    mem_wr_ready = 1;
    set1(32'h100, 32'h11); set2(32'h104, 32'h22);
    cyc();
    chk("dual_addr0", 64'(mem_wr_addr), 64'h100);
    chk("dual_data0", 64'(mem_wr_data), 64'h11);
    chk("dual_fwd", 64'(fwd_data), 64'h22);
    cyc();
    chk("dual_addr1", 64'(mem_wr_addr), 64'h104);
    chk("dual_data1", 64'(mem_wr_data), 64'h22);
    cyc();
    chk("dual_empty_valid", 64'(mem_wr_valid), 64'd0);
    chk("dual_empty_count", 64'(count), 64'd0);

    // Fill with memory stalled
    mem_wr_ready = 0;
    for (int i = 0; i < 8; i++) begin
      set1(32'h500 + 32'(4 * i), 32'hA0 + 32'(i));
      cyc();
      if (i == 5) chk("fill6_space2", 64'(space2), 64'd1);
      if (i == 6) chk("fill7_space2", 64'(space2), 64'd0);
    end
    chk("full_count", 64'(count), 64'd8);
    chk("full_hold_addr", 64'(mem_wr_addr), 64'h500);
    cyc();
    chk("stall_hold_addr", 64'(mem_wr_addr), 64'h500);

    // Full + pop + dual push: slot 1 takes the freed slot, slot 2 dropped
    mem_wr_ready = 1;
    set1(32'h600, 32'h66); set2(32'h604, 32'h67);
    cyc();
    chk("ovf_count", 64'(count), 64'd8);
    chk("ovf_flag", 64'(overflow), 64'd1);
    chk("ovf_head", 64'(mem_wr_addr), 64'h504);
    repeat (9) cyc();
    chk("drain_empty", 64'(mem_wr_valid), 64'd0);
    chk("ovf_sticky", 64'(overflow), 64'd1);

    // Forwarding: youngest match wins, in-flight enqueue not searched
    mem_wr_ready = 0; fwd_addr = 32'h200;
    set1(32'h200, 32'hAA); cyc();
    set1(32'h208, 32'hCC); cyc();
    chk("fwd_old", 64'(fwd_data), 64'hAA);
    set1(32'h200, 32'hBB); cyc();
    chk("fwd_hit_young", 64'(fwd_hit), 64'd1);
    chk("fwd_data_young", 64'(fwd_data), 64'hBB);
    fwd_addr = 32'h204; #1;
    chk("fwd_miss_hit", 64'(fwd_hit), 64'd0);
    chk("fwd_miss_data", 64'(fwd_data), 64'd0);
    fwd_addr = 32'h200; mem_wr_ready = 1;
    repeat (3) cyc();

    // Slot 2 alone
    mem_wr_ready = 0;
    set2(32'h300, 32'h33); cyc();
    chk("r2_count", 64'(count), 64'd1);
    chk("r2_addr", 64'(mem_wr_addr), 64'h300);
    chk("r2_data", 64'(mem_wr_data), 64'h33);
    mem_wr_ready = 1; cyc();
    chk("r2_drained", 64'(count), 64'd0);

    // Asynchronous reset with 5 pending
    mem_wr_ready = 0;
    set1(32'h700, 32'h70); set2(32'h704, 32'h71); cyc();
    set1(32'h708, 32'h72); set2(32'h70C, 32'h73); cyc();
    set1(32'h710, 32'h74); cyc();
    chk("pre_rst_count", 64'(count), 64'd5);
    rst_n = 0; #1;
    chk("arst_count", 64'(count), 64'd0);
    chk("arst_valid", 64'(mem_wr_valid), 64'd0);
    chk("arst_space2", 64'(space2), 64'd1);
    chk("arst_overflow", 64'(overflow), 64'd0);
    cyc();
    rst_n = 1; mem_wr_ready = 1;
    repeat (4) cyc();
    chk("post_rst_valid", 64'(mem_wr_valid), 64'd0);

    cmp_en = 0;
    $display("%0d/%0d checks passed", n_pass, n_tot);
    $finish;
  end
endmodule
